// File: rtl/fc_layer.sv
// Fully-connected layer: streams DIM_INPUT signed samples through a MAC bank of
// DIM_OUTPUT neurons, then adds bias, requantizes (round, shift, ReLU, saturate).
module fc_layer #(
    parameter int DIM_INPUT  = 96,
    parameter int DIM_OUTPUT = 8,
    parameter int INPUT_W    = 16,
    parameter int OUTPUT_W   = 8,
    parameter int WEIGHT_W   = 8,
    parameter int ACC_W      = 32,
    parameter int SHIFT      = 8,
    parameter int RELU       = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  fc_in_vld,
    input  logic signed [INPUT_W-1:0]             fc_in_dat,
    output logic                                  fc_out_vld,
    output logic signed [OUTPUT_W-1:0]            fc_out_dat [DIM_OUTPUT-1:0],
    input  logic                                  w_wr_en,
    input  logic [$clog2(DIM_INPUT+1)-1:0]        w_wr_addr,
    input  logic [DIM_OUTPUT*WEIGHT_W-1:0]        w_wr_dat,
    output logic                                  busy,
    output logic                                  err
);
    localparam int AW = $clog2(DIM_INPUT+1);
    localparam int RW = DIM_OUTPUT*WEIGHT_W;
    localparam logic [AW-1:0] LAST_IDX = AW'(DIM_INPUT-1);
    localparam logic [AW-1:0] BIAS_IDX = AW'(DIM_INPUT);
    localparam logic signed [ACC_W-1:0] RND  = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT-1);
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUTPUT_W+1){1'b0}}, {(OUTPUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, REQ = 2'd2} state_t;

    state_t                      state_q, state_d;
    logic [RW-1:0]               mem_q [DIM_INPUT+1];
    logic [AW-1:0]               cnt_q, cnt_d;
    logic signed [ACC_W-1:0]     acc_q [DIM_OUTPUT-1:0];
    logic signed [ACC_W-1:0]     acc_d [DIM_OUTPUT-1:0];
    logic signed [OUTPUT_W-1:0]  out_q [DIM_OUTPUT-1:0];
    logic signed [OUTPUT_W-1:0]  out_d [DIM_OUTPUT-1:0];
    logic                        vld_q, vld_d;
    logic                        err_q, err_d;
    logic [RW-1:0]               rd_row;
    logic [RW-1:0]               bias_row;
    logic                        wr_ok;

    function automatic logic signed [ACC_W-1:0] mul_ext(
        input logic signed [INPUT_W-1:0]  x,
        input logic signed [WEIGHT_W-1:0] w
    );
        logic signed [INPUT_W+WEIGHT_W-1:0] p;
        p = x * w;
        return ACC_W'(p);
    endfunction

    function automatic logic signed [ACC_W-1:0] round_shift(
        input logic signed [ACC_W-1:0]    acc,
        input logic signed [WEIGHT_W-1:0] b
    );
        logic signed [ACC_W-1:0] s;
        s = acc + ACC_W'(b) + RND;
        return s >>> SHIFT;
    endfunction

    function automatic logic signed [OUTPUT_W-1:0] relu_sat(
        input logic signed [ACC_W-1:0] y
    );
        logic signed [ACC_W-1:0] t;
        t = y;
        if (RELU != 0 && t < 0) t = '0;
        if (t > OMAX) t = OMAX;
        else if (t < OMIN) t = OMIN;
        return OUTPUT_W'(t);
    endfunction

    // Parameter store: no reset so weights survive rst.
    assign wr_ok = w_wr_en && (state_q == IDLE) && (w_wr_addr <= BIAS_IDX);

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[w_wr_addr] <= w_wr_dat;
    end

    always_comb begin
        rd_row   = (state_q == IDLE) ? mem_q[0] : mem_q[cnt_q];
        bias_row = mem_q[DIM_INPUT];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fc_in_vld) state_d = ACC;
            ACC:     if (fc_in_vld && cnt_q == LAST_IDX) state_d = REQ;
            REQ:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // MAC / requantization datapath
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        out_d = out_q;
        vld_d = 1'b0;
        err_d = err_q;
        unique case (state_q)
            IDLE: begin
                if (fc_in_vld) begin
                    for (int j = 0; j < DIM_OUTPUT; j++)
                        acc_d[j] = mul_ext(fc_in_dat, $signed(rd_row[j*WEIGHT_W +: WEIGHT_W]));
                    cnt_d = AW'(1);
                end
            end
            ACC: begin
                if (fc_in_vld) begin
                    for (int j = 0; j < DIM_OUTPUT; j++)
                        acc_d[j] = acc_q[j] + mul_ext(fc_in_dat, $signed(rd_row[j*WEIGHT_W +: WEIGHT_W]));
                    cnt_d = cnt_q + AW'(1);
                end
            end
            REQ: begin
                for (int j = 0; j < DIM_OUTPUT; j++)
                    out_d[j] = relu_sat(round_shift(acc_q[j], $signed(bias_row[j*WEIGHT_W +: WEIGHT_W])));
                vld_d = 1'b1;
                cnt_d = '0;
                if (fc_in_vld) err_d = 1'b1;
            end
            default: cnt_d = '0;
        endcase
        if (w_wr_en && (state_q != IDLE || w_wr_addr > BIAS_IDX)) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            vld_q <= 1'b0;
            err_q <= 1'b0;
            for (int j = 0; j < DIM_OUTPUT; j++) begin
                acc_q[j] <= '0;
                out_q[j] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            err_q <= err_d;
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign fc_out_vld = vld_q;
    assign fc_out_dat = out_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer: two instances (RELU=1 and RELU=0) share stimulus.
module tb_fc_layer;
    localparam int DI = 96;
    localparam int DO = 8;

    logic clk = 1'b0;
    logic rst;
    logic fc_in_vld;
    logic signed [15:0] fc_in_dat;
    logic w_wr_en;
    logic [6:0] w_wr_addr;
    logic [63:0] w_wr_dat;
    logic fc_out_vld, vld0, busy, busy0, err, err0;
    logic signed [7:0] fc_out_dat [DO-1:0];
    logic signed [7:0] dat0 [DO-1:0];

    int n_chk = 0;
    int n_err = 0;
    int e1 [DO];
    int e0 [DO];

    always #5 clk = ~clk;

    fc_layer #(.RELU(1)) u_dut (
        .clk(clk), .rst(rst), .fc_in_vld(fc_in_vld), .fc_in_dat(fc_in_dat),
        .fc_out_vld(fc_out_vld), .fc_out_dat(fc_out_dat),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_dat(w_wr_dat),
        .busy(busy), .err(err)
    );

    fc_layer #(.RELU(0)) u_dut0 (
        .clk(clk), .rst(rst), .fc_in_vld(fc_in_vld), .fc_in_dat(fc_in_dat),
        .fc_out_vld(vld0), .fc_out_dat(dat0),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_dat(w_wr_dat),
        .busy(busy0), .err(err0)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input int v1, input int v0);
        for (int j = 0; j < DO; j++) begin
            e1[j] = v1;
            e0[j] = v0;
        end
    endtask

    task automatic chk_outs(input string tag);
        for (int j = 0; j < DO; j++) begin
            chk($sformatf("%s_r1[%0d]", tag, j), 32'(fc_out_dat[j]), e1[j]);
            chk($sformatf("%s_r0[%0d]", tag, j), 32'(dat0[j]), e0[j]);
        end
    endtask

    task automatic write_row(input logic [6:0] addr, input logic [63:0] data);
        w_wr_en   = 1'b1;
        w_wr_addr = addr;
        w_wr_dat  = data;
        tick();
        w_wr_en   = 1'b0;
    endtask

    task automatic load_w(input logic [63:0] row, input logic [63:0] bias);
        for (int r = 0; r < DI; r++) write_row(7'(r), row);
        write_row(7'(DI), bias);
    endtask

    function automatic logic [63:0] row_pat(input bit neg);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < DO; j++) r[j*8 +: 8] = neg ? 8'(-(j+1)) : 8'(j+1);
        return r;
    endfunction

    // Sends n samples (x0 first, xr after); optional idle gap between samples
    // and an optional parameter write alongside sample wr_at.
    task automatic send_frame(input int n, input logic signed [15:0] x0, input logic signed [15:0] xr,
                              input bit gaps, input int wr_at);
        for (int i = 0; i < n; i++) begin
            fc_in_vld = 1'b1;
            fc_in_dat = (i == 0) ? x0 : xr;
            if (i == wr_at) begin
                w_wr_en   = 1'b1;
                w_wr_addr = 7'd50;
                w_wr_dat  = {8{8'h05}};
            end
            tick();
            w_wr_en = 1'b0;
            if (i == 0) chk("busy_frame", 32'(busy), 1);
            if (gaps && i != n-1) begin
                fc_in_vld = 1'b0;
                fc_in_dat = 16'($urandom);
                tick();
            end
        end
        fc_in_vld = 1'b0;
    endtask

    // Called in the cycle after the last sample; pulse is due one tick later.
    task automatic wait_pulse(input string tag);
        int lat;
        lat = -1;
        fc_in_vld = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            tick();
            if (fc_out_vld) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_vld0"}, 32'(vld0), 1);
        chk_outs(tag);
        tick();
        chk({tag, "_pulse_end"}, 32'(fc_out_vld), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
        chk_outs({tag, "_hold"});
    endtask

    initial begin
        int seen;
        rst = 1'b1; fc_in_vld = 1'b0; fc_in_dat = '0;
        w_wr_en = 1'b0; w_wr_addr = '0; w_wr_dat = '0;
        repeat (3) tick();
        chk("rst_vld", 32'(fc_out_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err0", 32'(err0), 0);
        set_exp(0, 0);
        chk_outs("rst");
        rst = 1'b0;
        tick();

        load_w({8{8'h01}}, '0);
        chk("load_err", 32'(err), 0);

        send_frame(DI, 16'sd256, 16'sd256, 1'b0, -1);
        set_exp(96, 96);
        wait_pulse("nom");

        send_frame(DI, 16'sd256, 16'sd256, 1'b1, -1);
        wait_pulse("gap");

        load_w(row_pat(1'b0), '0);
        send_frame(DI, 16'sd16, 16'sd16, 1'b0, -1);
        for (int j = 0; j < DO; j++) begin e1[j] = 6*(j+1); e0[j] = 6*(j+1); end
        wait_pulse("pat");

        load_w(row_pat(1'b1), '0);
        send_frame(DI, 16'sd16, 16'sd16, 1'b0, -1);
        for (int j = 0; j < DO; j++) begin e1[j] = 0; e0[j] = -6*(j+1); end
        wait_pulse("neg");

        load_w({8{8'h01}}, '0);
        send_frame(DI, 16'sd128, 16'sd0, 1'b0, -1);
        set_exp(1, 1);
        wait_pulse("rnd128");
        send_frame(DI, 16'sd127, 16'sd0, 1'b0, -1);
        set_exp(0, 0);
        wait_pulse("rnd127");

        write_row(7'(DI), 64'hFF00_FF00_FF00_FF00);
        send_frame(DI, 16'sd128, 16'sd0, 1'b0, -1);
        for (int j = 0; j < DO; j++) begin e1[j] = (j % 2 == 0) ? 1 : 0; e0[j] = e1[j]; end
        wait_pulse("bias");

        load_w({8{8'h7F}}, '0);
        send_frame(DI, 16'h7FFF, 16'h7FFF, 1'b0, -1);
        set_exp(127, 127);
        wait_pulse("satp");

        load_w({8{8'h81}}, '0);
        send_frame(DI, 16'h7FFF, 16'h7FFF, 1'b0, -1);
        set_exp(0, -128);
        wait_pulse("satn");
        chk("sat_err", 32'(err), 0);

        // back-to-back frames: B's first sample rides the A pulse cycle
        load_w({8{8'h01}}, '0);
        send_frame(DI, 16'sd256, 16'sd256, 1'b0, -1);
        tick();
        chk("b2b_vldA", 32'(fc_out_vld), 1);
        set_exp(96, 96);
        chk_outs("b2bA");
        send_frame(DI, 16'sd16, 16'sd16, 1'b0, -1);
        chk_outs("b2b_holdA");
        set_exp(6, 6);
        wait_pulse("b2bB");

        // write during ACC is dropped and flags err
        send_frame(DI, 16'sd256, 16'sd256, 1'b0, 3);
        chk("wr_acc_err", 32'(err), 1);
        set_exp(96, 96);
        wait_pulse("wr_acc");

        // sample during REQ is dropped and flags err
        send_frame(DI, 16'sd256, 16'sd256, 1'b0, -1);
        fc_in_vld = 1'b1;
        fc_in_dat = 16'sd1000;
        tick();
        fc_in_vld = 1'b0;
        chk("reqdrop_vld", 32'(fc_out_vld), 1);
        chk("reqdrop_busy", 32'(busy), 0);
        chk("reqdrop_err", 32'(err), 1);
        chk_outs("reqdrop");
        tick();
        send_frame(DI, 16'sd16, 16'sd16, 1'b0, -1);
        set_exp(6, 6);
        wait_pulse("after_drop");

        // rst clears err, keeps weights; out-of-range write flags err
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_err", 32'(err), 0);
        set_exp(0, 0);
        chk_outs("rst2");
        write_row(7'd100, {8{8'h33}});
        chk("badaddr_err", 32'(err), 1);
        send_frame(DI, 16'sd256, 16'sd256, 1'b0, -1);
        set_exp(96, 96);
        wait_pulse("keepw");

        // mid-frame reset discards the partial frame
        send_frame(50, 16'sd256, 16'sd256, 1'b0, -1);
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_err", 32'(err), 0);
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            tick();
            if (fc_out_vld || vld0) seen++;
        end
        chk("abort_nopulse", seen, 0);
        send_frame(DI, 16'sd256, 16'sd256, 1'b0, -1);
        wait_pulse("abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fc_layer.md
FC_LAYER -- requirements
Module: fc_layer

Interface
REQ-001 Parameters SHALL be: DIM_INPUT 96, inputs per frame (>=2); DIM_OUTPUT 8, neurons; INPUT_W 16, signed input width; OUTPUT_W 8, signed output width; WEIGHT_W 8, signed weight width; ACC_W 32, accumulator width; SHIFT 8, requantization right shift (>=1); RELU 1, clamp negatives to 0 when 1.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 fc_in_vld  in  1  input sample valid, one sample per high cycle, gaps allowed.
REQ-006 fc_in_dat  in  INPUT_W  signed input sample, sampled when fc_in_vld=1.
REQ-007 fc_out_vld  out  1  one-cycle result pulse.
REQ-008 fc_out_dat  out  OUTPUT_W x DIM_OUTPUT (unpacked array [DIM_OUTPUT-1:0])  signed neuron results, held until the next pulse.
REQ-009 w_wr_en  in  1  parameter write strobe.
REQ-010 w_wr_addr  in  $clog2(DIM_INPUT+1)  row index: 0..DIM_INPUT-1 weight rows, DIM_INPUT bias row.
REQ-011 w_wr_dat  in  DIM_OUTPUT*WEIGHT_W  row data; neuron j at bits [j*WEIGHT_W +: WEIGHT_W]; in the bias row each field is a signed bias.
REQ-012 busy  out  1  high while a frame is in progress (ACC or REQ).
REQ-013 err  out  1  sticky error flag, cleared only by rst.

Function
REQ-014 Parameter store SHALL be a register array of DIM_INPUT+1 rows, written on the rising edge when w_wr_en=1 and state is IDLE, read asynchronously.
REQ-015 Writes with w_wr_en=1 while busy=1, or with w_wr_addr>DIM_INPUT, SHALL be dropped and SHALL set err.
REQ-016 FSM states SHALL be IDLE, ACC, REQ; no other state is reachable.
REQ-017 IDLE: on fc_in_vld, acc[j] <= x*w[0][j], cnt <= 1, go to ACC; otherwise hold.
REQ-018 ACC: on fc_in_vld, acc[j] <= acc[j] + x*w[cnt][j] and cnt <= cnt+1; when cnt==DIM_INPUT-1 on a valid sample, go to REQ; fc_in_vld=0 holds all state.
REQ-019 Product SHALL be signed INPUT_W x WEIGHT_W, sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W (no overflow occurs at the default parameters).
REQ-020 REQ (exactly one cycle): per neuron, s = acc + sign-extended bias + 2^(SHIFT-1); y = s arithmetic-shifted right by SHIFT; if RELU=1 and y<0 then y=0; saturate y to [-2^(OUTPUT_W-1), 2^(OUTPUT_W-1)-1]; register y into fc_out_dat[j], set fc_out_vld, go to IDLE.
REQ-021 Latency: last sample accepted in cycle T -> fc_out_vld high in cycle T+2, for exactly one cycle.
REQ-022 fc_in_vld=1 during REQ SHALL be ignored (sample dropped) and SHALL set err.
REQ-023 A new frame's first sample SHALL be accepted in IDLE in the same cycle fc_out_vld is high.
REQ-024 fc_out_dat SHALL change only on the cycle-edge that raises fc_out_vld.
REQ-025 busy SHALL be 1 in ACC and REQ, 0 in IDLE.

Reset
REQ-026 On rst: state IDLE, cnt 0, all acc 0, fc_out_vld 0, every fc_out_dat[j] 0, busy 0, err 0.
REQ-027 Parameter rows SHALL NOT be reset; contents are preserved across rst.
REQ-028 rst asserted mid-frame SHALL discard the partial frame with no fc_out_vld pulse; the next frame SHALL start at index 0.

Verification
REQ-029 Reset: assert rst -> fc_out_vld=0, fc_out_dat all 0, busy=0, err=0.
REQ-030 Nominal: all weights 0x01, bias 0, 96 contiguous samples of 256 -> acc 24576, every output 96, fc_out_vld exactly 2 cycles after the 96th sample.
REQ-031 Gaps: same as REQ-030 with fc_in_vld toggling every cycle -> identical outputs, pulse 2 cycles after the last valid sample.
REQ-032 Rounding/saturation: a single input 128 with weight 1 -> 1; input 127 -> 0; weights 0x7F with inputs 0x7FFF -> 127; weight 0x81 with input 0x7FFF gives -128 with RELU=0 and 0 with RELU=1.
REQ-033 Errors: w_wr_en during ACC -> row unchanged, err=1; fc_in_vld during REQ -> sample dropped, err=1, results unchanged.
REQ-034 Mid-frame reset: rst after 50 samples, then a full REQ-030 frame -> no pulse for the aborted frame, outputs 96.
